uart_rx: RTL and testbench

- Asynchronous serial receiver: 8N1 frames from the ESP32 link in, ready/valid bytes out.
- Sits directly upstream of the skid buffer. data_o/valid_o/ready_i connect to the buffer's data_i/valid_i/ready_o.
- The buffer's rts_o goes straight to the ESP32 pin. It does not pass through this block.
- Oversamples the line at a fixed clocks-per-bit rate, samples at mid-bit, rejects start-bit glitches, and flags framing and overrun errors.

---
 rtl/uart_rx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: asynchronous 8N1 serial receiver with ready/valid byte output.
//
// The line is brought into the clock domain through two flops. A falling edge on the
// synchronised line starts a frame. The start bit is re-checked at mid-bit so that short
// glitches are rejected. Data bits are then sampled once per bit period, LSB first, and
// the stop bit is checked. A good frame is committed into a single output register that
// feeds the downstream skid buffer.
//
// Optional feature: define UART_RX_PARITY_EN to expect a parity bit between the last data
// bit and the stop bit. Without it the frame is plain 8N1 and parity_err_o is tied low.
//
// Parameters:
//   width_p       data bits per frame (>= 2)
//   prescale_p    clock cycles per bit period (>= 4)
//   parity_odd_p  1: odd parity, 0: even parity (parity builds only)
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous active-high reset
//   rx_i          raw asynchronous serial line, idles high
//   data_o        received byte
//   valid_o       data_o holds an unconsumed byte
//   ready_i       downstream accepts data_o this cycle
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   overrun_o     one-cycle pulse: byte completed while output full and not draining
//   parity_err_o  one-cycle pulse: parity mismatch
module uart_rx #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned prescale_p   = 217,
  parameter bit          parity_odd_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               rx_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               frame_err_o,
  output logic               overrun_o,
  output logic               parity_err_o
);

  localparam int unsigned TickW = $clog2(prescale_p);
  localparam int unsigned BitW  = $clog2(width_p + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(prescale_p - 1);
  // Start bit is re-sampled half a bit period after the falling edge.
  localparam logic [TickW-1:0] HalfLast = TickW'(prescale_p / 2 - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(width_p - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e             state_q;
  logic               rx_meta_q;
  logic               rx_sync_q;
  logic               rx_prev_q;
  logic [TickW-1:0]   tick_q;
  logic [BitW-1:0]    bit_q;
  logic [width_p-1:0] shift_q;
  logic [width_p-1:0] data_q;
  logic               valid_q;
  logic               frame_err_q;
  logic               overrun_q;
`ifdef UART_RX_PARITY_EN
  logic               parity_err_q;
  logic               par_bad_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Handshake drain; a commit later in this block may re-assert valid.
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      tick_q <= tick_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          tick_q <= '0;
          bit_q  <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad_q <= 1'b0;
`endif
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          if (tick_q == HalfLast) begin
            tick_q  <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_q <= rx_sync_q ? StIdle : StData;
          end
        end

        StData: begin
          if (tick_q == TickLast) begin
            tick_q  <= '0;
            shift_q <= {rx_sync_q, shift_q[width_p-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick_q == TickLast) begin
            tick_q    <= '0;
            par_bad_q <= rx_sync_q != ((^shift_q) ^ parity_odd_p);
            state_q   <= StStop;
          end
        end
`endif

        StStop: begin
          if (tick_q == TickLast) begin
            tick_q <= '0;
`ifdef UART_RX_PARITY_EN
            // A parity error takes precedence over a framing error.
            if (par_bad_q) begin
              parity_err_q <= 1'b1;
            end else if (!rx_sync_q) begin
              frame_err_q <= 1'b1;
            end else if (valid_q && !ready_i) begin
              overrun_q <= 1'b1;
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
`else
            if (!rx_sync_q) begin
              frame_err_q <= 1'b1;
            end else if (valid_q && !ready_i) begin
              overrun_q <= 1'b1;
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
`endif
            // A low stop bit may be a held break; wait for the line to rise first.
            state_q <= rx_sync_q ? StIdle : StBreak;
          end
        end

        StBreak: begin
          tick_q <= '0;
          if (rx_sync_q) begin
            state_q <= StIdle;
          end
        end

        default: begin
          tick_q  <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  // No parity bit in the frame; parity_odd_p has no effect in this build.
  assign parity_err_o = parity_odd_p & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at prescale_p = 8. A table of single frames is applied
// in a loop, followed by hand-written sequences for glitch, break, overrun, commit-cycle
// handshake and mid-frame reset.
module tb_uart_rx;

  localparam int P = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Cycles from the start-bit drive edge to the first cycle valid_o is high.
  localparam int LAT = 79 + P * PAR;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  uart_rx #(
    .width_p     (8),
    .prescale_p  (P),
    .parity_odd_p(1'b0)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk_i) cyc++;

  // Monitor: only accumulates; tests compare deltas against snapshots.
  logic [7:0] got_q[$];
  int n_ferr = 0, n_ovr = 0, n_perr = 0, n_vcyc = 0, n_unstable = 0;
  int first_vcyc = 0;
  logic vprev = 1'b0;
  logic hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk_i) begin
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (valid_o) n_vcyc++;
    if (valid_o && !vprev) first_vcyc = cyc;
    if (hold_prev && valid_o && (data_o != data_prev)) n_unstable++;
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    if (parity_err_o) n_perr++;
    vprev = valid_o;
    hold_prev = valid_o && !ready_i;
    data_prev = data_o;
  end

  int b_bytes, b_ferr, b_ovr, b_perr, b_vcyc;

  task automatic snap();
    b_bytes = got_q.size();
    b_ferr  = n_ferr;
    b_ovr   = n_ovr;
    b_perr  = n_perr;
    b_vcyc  = n_vcyc;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All drive tasks start and end 1 ns after a rising edge.
  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (P) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx_i = 1'b1;  // parity bit not sent in 8N1 builds
`endif
    drive_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Even parity bits: A5->0, 00->0, FF->0, 3C->0, 01->1, 80->1, 07->1.
    vecs.push_back('{8'hA5, 1'b0, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 1, 0, 0});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h80, 1'b1, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b0, 1'b1, 0, 0, 1});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 0, 0, 1});
`endif

    reset_i = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset data_o", int'(data_o), 0);
    check("reset valid_o", int'(valid_o), 0);
    check("reset err pulses", int'({frame_err_o, overrun_o, parity_err_o}), 0);
    reset_i = 1'b0;
    idle(10);

    // Table of single frames with ready held high.
    ready_i = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      idle(20);
      check($sformatf("vec%0d bytes", i), got_q.size() - b_bytes, vecs[i].exp_bytes);
      check($sformatf("vec%0d valid cycles", i), n_vcyc - b_vcyc, vecs[i].exp_bytes);
      check($sformatf("vec%0d frame_err", i), n_ferr - b_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d parity_err", i), n_perr - b_perr, vecs[i].exp_perr);
      check($sformatf("vec%0d overrun", i), n_ovr - b_ovr, 0);
      if (vecs[i].exp_bytes == 1 && got_q.size() > b_bytes) begin
        check($sformatf("vec%0d data", i), int'(got_q[b_bytes]), int'(vecs[i].data));
        check($sformatf("vec%0d latency", i), first_vcyc - start_cyc, LAT);
      end
    end

    // 3-cycle low glitch on an idle line is ignored; next frame still received.
    snap();
    rx_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    idle(40);
    check("glitch valid cycles", n_vcyc - b_vcyc, 0);
    check("glitch frame_err", n_ferr - b_ferr, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(20);
    check("post-glitch bytes", got_q.size() - b_bytes, 1);
    if (got_q.size() > b_bytes) check("post-glitch data", int'(got_q[b_bytes]), 8'h5A);

    // Low stop bit, line held low (break), then release and receive 0x01.
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    idle(20);
    check("break frame_err", n_ferr - b_ferr, 1);
    check("break valid cycles", n_vcyc - b_vcyc, 0);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);
    check("post-break bytes", got_q.size() - b_bytes, 1);
    if (got_q.size() > b_bytes) check("post-break data", int'(got_q[b_bytes]), 8'h01);
    check("post-break frame_err", n_ferr - b_ferr, 1);

    // Overrun: two back-to-back frames while ready is low.
    snap();
    ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(20);
    check("overrun held valid", int'(valid_o), 1);
    check("overrun held data", int'(data_o), 8'h11);
    check("overrun pulses", n_ovr - b_ovr, 1);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    idle(5);
    check("overrun drained bytes", got_q.size() - b_bytes, 1);
    if (got_q.size() > b_bytes) check("overrun drained data", int'(got_q[b_bytes]), 8'h11);
    check("overrun valid after drain", int'(valid_o), 0);

    // ready rises exactly in the stop-sample cycle of 0x22 while 0x11 is held.
    snap();
    send_frame(8'h11, 1'b0, 1'b1);
    fork
      send_frame(8'h22, 1'b0, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check("commit-ready valid", int'(valid_o), 1);
        check("commit-ready data", int'(data_o), 8'h22);
      end
    join
    idle(10);
    check("commit-ready overrun", n_ovr - b_ovr, 0);
    check("commit-ready bytes", got_q.size() - b_bytes, 1);
    if (got_q.size() > b_bytes) check("commit-ready first", int'(got_q[b_bytes]), 8'h11);
    ready_i = 1'b1;
    idle(3);
    check("commit-ready drain", got_q.size() - b_bytes, 2);
    if (got_q.size() > b_bytes + 1) check("commit-ready second", int'(got_q[b_bytes+1]), 8'h22);

    // Reset mid-DATA with a byte held: everything clears, next frame is clean.
    ready_i = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(5);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset_i = 1'b1;
    rx_i    = 1'b1;
    @(posedge clk_i);
    #1;
    check("mid-reset valid_o", int'(valid_o), 0);
    check("mid-reset data_o", int'(data_o), 0);
    check("mid-reset err pulses", int'({frame_err_o, overrun_o, parity_err_o}), 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    idle(30);
    snap();
    ready_i = 1'b1;
    send_frame(8'h96, 1'b0, 1'b1);
    idle(20);
    check("post-reset bytes", got_q.size() - b_bytes, 1);
    if (got_q.size() > b_bytes) check("post-reset data", int'(got_q[b_bytes]), 8'h96);
    check("post-reset errors", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);

    check("data stable while stalled", n_unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
